axi_slave_mem: RTL and testbench

AXI3 slave (responder) with a built-in 32-bit word-addressed memory. It is the far end of the AXI interface that the verification component drives as a master. It accepts write and read bursts (FIXED/INCR/WRAP, byte strobes, 4-bit IDs) and returns B and R responses, which makes it the DUT/reference target for the byte-level scoreboard. Write and read paths are independent FSMs, each with one outstanding transaction.

---
 rtl/axi_slave_mem.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI3 slave with an internal 32-bit word memory.
// Write and read paths are independent FSMs, each holding one outstanding burst.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, consuming len+1 write beats
// W_RESP | bvalid high, holding the write response until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting one registered beat per handshake
module axi_slave_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic burst_err(input logic [31:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
    return (size > 3'b010) || (burst == 2'b11) || bad_wrap || !in_range(a);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] wrap_bytes;
    step       = 32'd1 << size;
    wrap_bytes = ({28'd0, len} + 32'd1) << size;
    case (burst)
      2'b01:   return a + step;
      2'b10:   return (a & ~(wrap_bytes - 32'd1)) | ((a + step) & (wrap_bytes - 32'd1));
      default: return a;
    endcase
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  logic [31:0] mem_q [MEM_WORDS];

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_id_q, w_id_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic        w_berr_q, w_berr_d, w_err_q, w_err_d;
  logic        w_beat_last, w_beat_bad, mem_we;
  logic [IDX_W-1:0] mem_widx;

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [31:0] r_addr_q, r_addr_d, r_addr_nxt, r_data_q, r_data_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic        r_berr_q, r_berr_d;

  assign awready = (w_state_q == W_IDLE) && !arst;
  assign wready  = (w_state_q == W_DATA) && !arst;
  assign bvalid  = (w_state_q == W_RESP) && !arst;
  assign bid     = w_id_q;
  assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign arready = (r_state_q == R_IDLE) && !arst;
  assign rvalid  = (r_state_q == R_DATA) && !arst;
  assign rid     = r_id_q;
  assign rdata   = r_data_q;
  assign rlast   = rvalid && (r_cnt_q == r_len_q);
  assign rresp   = (rvalid && (r_berr_q || !in_range(r_addr_q))) ? RESP_SLVERR : RESP_OKAY;

  // Write path next state: capture AW, consume beats, flag any error, then respond.
  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_berr_d    = w_berr_q;
    w_err_d     = w_err_q;
    mem_we      = 1'b0;
    mem_widx    = word_idx(w_addr_q);
    w_beat_last = (w_cnt_q == w_len_q);
    w_beat_bad  = w_berr_q || !in_range(w_addr_q);
    unique case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        w_id_d    = awid;
        w_addr_d  = awaddr;
        w_len_d   = awlen;
        w_size_d  = awsize;
        w_burst_d = awburst;
        w_cnt_d   = 4'd0;
        w_berr_d  = burst_err(awaddr, awlen, awsize, awburst);
        w_err_d   = burst_err(awaddr, awlen, awsize, awburst);
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready) begin
        mem_we = !w_beat_bad;
        if (w_beat_bad || (wid != w_id_q) || (wlast != w_beat_last)) w_err_d = 1'b1;
        if (w_beat_last) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d  = w_cnt_q + 4'd1;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        end
      end
      W_RESP: if (bvalid && bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write path registers.
  always_ff @(posedge aclk) begin
    if (arst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_berr_q  <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_berr_q  <= w_berr_d;
      w_err_q   <= w_err_d;
    end
  end

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read path next state: the next beat's word is fetched into r_data on each
  // handshake, so a write landing on the same edge is not yet visible.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_size_d   = r_size_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    r_berr_d   = r_berr_q;
    r_data_d   = r_data_q;
    r_addr_nxt = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    unique case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        r_id_d    = arid;
        r_addr_d  = araddr;
        r_len_d   = arlen;
        r_size_d  = arsize;
        r_burst_d = arburst;
        r_cnt_d   = 4'd0;
        r_berr_d  = burst_err(araddr, arlen, arsize, arburst);
        r_data_d  = burst_err(araddr, arlen, arsize, arburst) ? 32'd0 : mem_q[word_idx(araddr)];
        r_state_d = R_DATA;
      end
      R_DATA: if (rvalid && rready) begin
        if (rlast) begin
          r_data_d  = 32'd0;
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d  = r_cnt_q + 4'd1;
          r_addr_d = r_addr_nxt;
          r_data_d = (r_berr_q || !in_range(r_addr_nxt)) ? 32'd0 : mem_q[word_idx(r_addr_nxt)];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read path registers.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_berr_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_berr_q  <= r_berr_d;
      r_data_q  <= r_data_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: table of burst cases, hand-written
// corner sequences and randomized bursts checked against a byte-level model.
module tb_axi_slave_mem;
  localparam int MW = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic aclk, arst;
  logic [3:0] awid, awlen, awcache, wid, wstrb, bid, arid, arlen, arcache, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, awlock, bresp, arburst, arlock, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi_slave_mem #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_mem [MW];
  bit          mdl_known [MW];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_got [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [49:0] all_outs();
    return {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit m_in_range(input longint a);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * MW);
  endfunction

  function automatic int m_idx(input longint a);
    return int'((a - longint'(BASE)) / 4);
  endfunction

  function automatic bit m_burst_err(input longint a, input int len, input int size, input int burst);
    return (size > 2) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || !m_in_range(a);
  endfunction

  function automatic longint m_beat_addr(input longint start, input int len, input int size,
                                         input int burst, input int i);
    longint step, wb, lower;
    step = longint'(1) << size;
    case (burst)
      1: return start + longint'(i) * step;
      2: begin
        wb    = longint'(len + 1) * step;
        lower = (start / wb) * wb;
        return lower + ((start - lower) + longint'(i) * step) % wb;
      end
      default: return start;
    endcase
  endfunction

  // ---------------- bus tasks (called and return at a falling edge) ----------------
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_last, input bit bad_wid,
                           input bit bp, output logic [1:0] got_resp);
    int n;
    bit exp_err;
    longint ba;
    exp_err = m_burst_err(addr, len, size, burst) || bad_wid || (bad_last >= 0);
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      chk("aw_handshake_timeout", 1, 0);
      awvalid = 1'b0; got_resp = 2'bxx;
      return;
    end
    @(negedge aclk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
    for (int i = 0; i <= len; i++) begin
      if (bp && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
      wid   = (bad_wid && i == 0) ? ~id : id;
      wdata = wr_data[i];
      wstrb = wr_strb[i];
      wlast = (i == len) != (i == bad_last);
      wvalid = 1'b1;
      chk("wready_beat", wready, 1);
      @(negedge aclk);
      ba = m_beat_addr(addr, len, size, burst, i);
      if (!m_burst_err(addr, len, size, burst) && m_in_range(ba)) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[i][b]) mdl_mem[m_idx(ba)][8*b +: 8] = wr_data[i][8*b +: 8];
        if (wr_strb[i] == 4'hF) mdl_known[m_idx(ba)] = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      if (i < len) chk("bvalid_before_last", bvalid, 0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last", bvalid, 1);
    if (bp) begin
      repeat ($urandom_range(0, 3)) begin
        bready = 1'b0;
        chk("bvalid_held", bvalid, 1);
        chk("bid_held", bid, id);
        @(negedge aclk);
      end
    end
    chk("bid", bid, id);
    chk("bresp_model", bresp, exp_err ? SLVERR : OKAY);
    got_resp = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("awready_after_b", awready, 1);
    chk("bvalid_after_b", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input bit bp);
    int n, stall;
    bit bad, known;
    longint ba;
    logic [31:0] expd;
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      chk("ar_handshake_timeout", 1, 0);
      arvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ba    = m_beat_addr(addr, len, size, burst, i);
      bad   = m_burst_err(addr, len, size, burst) || !m_in_range(ba);
      expd  = bad ? 32'd0 : mdl_mem[m_idx(ba)];
      known = bad || mdl_known[m_idx(bad ? longint'(BASE) : ba)];
      stall = bp ? $urandom_range(0, 2) : 0;
      for (int s = 0; s <= stall; s++) begin
        rready = (s == stall);
        chk("rvalid", rvalid, 1);
        chk("rid", rid, id);
        chk("rresp", rresp, bad ? SLVERR : OKAY);
        chk("rlast", rlast, i == len);
        if (known) chk("rdata", rdata, expd);
        rd_got[i] = rdata;
        @(negedge aclk);
      end
    end
    rready = 1'b0;
    chk("arready_after_rlast", arready, 1);
    chk("rvalid_after_rlast", rvalid, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          size;
    int          burst;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int len, size, burst;
    logic [31:0] addr;

    tbl[0]  = '{BASE + 32'h20, 2, 2, 0, OKAY, "fixed"};
    tbl[1]  = '{BASE + 32'h30, 7, 2, 1, OKAY, "incr8"};
    tbl[2]  = '{BASE + 32'h64, 3, 2, 2, OKAY, "wrap4"};
    tbl[3]  = '{BASE + 32'h80, 2, 2, 2, SLVERR, "wrap_len2"};
    tbl[4]  = '{BASE + 32'h90, 1, 3, 1, SLVERR, "size3"};
    tbl[5]  = '{BASE + 32'hA0, 1, 2, 3, SLVERR, "burst3"};
    tbl[6]  = '{BASE - 32'd4, 0, 2, 1, SLVERR, "below_base"};
    tbl[7]  = '{BASE + 32'(4 * MW) - 32'd4, 1, 2, 1, SLVERR, "end_cross"};
    tbl[8]  = '{BASE + 32'(4 * MW), 0, 2, 1, SLVERR, "past_end"};
    tbl[9]  = '{BASE + 32'hB2, 3, 1, 1, OKAY, "narrow_half"};
    tbl[10] = '{BASE + 32'hC5, 15, 0, 2, OKAY, "wrap16_byte"};

    for (int i = 0; i < MW; i++) mdl_known[i] = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
    arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    awvalid = 1; wvalid = 1; bready = 1; arvalid = 1; rready = 1;
    arst = 1'b1;

    // reset with all valids high
    repeat (3) begin
      @(negedge aclk);
      chk("reset_outputs", all_outs(), 0);
    end
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    arst = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    axi_write(4'd5, BASE + 32'h10, 3, 2, 1, -1, 0, 0, resp);
    chk("incr_bresp", resp, OKAY);
    axi_read(4'd6, BASE + 32'h10, 3, 2, 1, 0);
    for (int i = 0; i < 4; i++) chk("incr_readback", rd_got[i], 32'hA0 + 32'(i));

    // partial strobe merge
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    axi_write(4'd1, BASE + 32'h40, 0, 2, 1, -1, 0, 0, resp);
    wr_data[0] = 32'h00000011; wr_strb[0] = 4'b0001;
    axi_write(4'd2, BASE + 32'h40, 0, 2, 1, -1, 0, 0, resp);
    axi_read(4'd3, BASE + 32'h40, 0, 2, 1, 0);
    chk("strobe_merge", rd_got[0], 32'hDEADBE11);

    // WRAP read order
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11 * 32'(i + 1); wr_strb[i] = 4'hF; end
    axi_write(4'd4, BASE, 3, 2, 1, -1, 0, 0, resp);
    axi_read(4'd7, BASE + 32'h8, 3, 2, 2, 0);
    chk("wrap_beat0", rd_got[0], 32'h33);
    chk("wrap_beat1", rd_got[1], 32'h44);
    chk("wrap_beat2", rd_got[2], 32'h11);
    chk("wrap_beat3", rd_got[3], 32'h22);

    // table of burst cases: bresp against table, read-back against model
    foreach (tbl[k]) begin
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      axi_write(4'(k), tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, -1, 0, 0, resp);
      chk(tbl[k].name, resp, tbl[k].exp_resp);
      axi_read(4'(k + 1), tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, 1);
    end

    // protocol errors on W channel still consume len+1 beats
    axi_write(4'd9, BASE + 32'hD0, 2, 2, 1, 0, 0, 0, resp);
    chk("early_wlast", resp, SLVERR);
    axi_write(4'd9, BASE + 32'hD0, 2, 2, 1, 2, 0, 0, resp);
    chk("missing_wlast", resp, SLVERR);
    axi_write(4'd9, BASE + 32'hD0, 1, 2, 1, -1, 1, 0, resp);
    chk("wid_mismatch", resp, SLVERR);

    // same word written and read concurrently: read sees old data
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    axi_write(4'd2, BASE + 32'hE0, 0, 2, 1, -1, 0, 0, resp);
    awid = 4'd3; awaddr = BASE + 32'hE0; awlen = 0; awsize = 2; awburst = 1; awvalid = 1;
    arid = 4'd4; araddr = BASE + 32'hE0; arlen = 1; arsize = 2; arburst = 0; arvalid = 1;
    chk("conc_both_ready", {awready, arready}, 2'b11);
    @(negedge aclk);
    awvalid = 0; arvalid = 0;
    chk("conc_beat0_old", {rvalid, rdata}, {1'b1, 32'h12345678});
    wid = 4'd3; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1; wvalid = 1; rready = 1;
    @(negedge aclk);
    wvalid = 0; wlast = 0;
    chk("conc_bvalid", {bvalid, bid, bresp}, {1'b1, 4'd3, OKAY});
    chk("conc_beat1_old", {rvalid, rlast, rdata}, {2'b11, 32'h12345678});
    bready = 1;
    @(negedge aclk);
    rready = 0; bready = 0;
    chk("conc_both_idle", {awready, arready, bvalid, rvalid}, 4'b1100);
    mdl_mem[m_idx(longint'(BASE) + 32'hE0)] = 32'hCAFEF00D;
    axi_read(4'd5, BASE + 32'hE0, 0, 2, 1, 0);
    chk("conc_new_data", rd_got[0], 32'hCAFEF00D);

    // reset in the middle of a write burst
    awid = 4'd7; awaddr = BASE + 32'hF0; awlen = 3; awsize = 2; awburst = 1; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      wid = 4'd7; wdata = 32'h55AA0000 + 32'(i); wstrb = 4'hF; wlast = 0; wvalid = 1;
      @(negedge aclk);
      mdl_mem[m_idx(longint'(BASE) + 32'hF0 + 4 * i)] = 32'h55AA0000 + 32'(i);
      mdl_known[m_idx(longint'(BASE) + 32'hF0 + 4 * i)] = 1'b1;
    end
    wvalid = 0;
    arst = 1;
    @(negedge aclk);
    chk("reset_mid_outputs", all_outs(), 0);
    arst = 0;
    @(negedge aclk);
    chk("reset_mid_idle", {awready, wready, bvalid, arready}, 4'b1001);
    repeat (3) begin
      @(negedge aclk);
      chk("reset_mid_no_b", bvalid, 0);
    end
    axi_read(4'd8, BASE + 32'hF0, 1, 2, 1, 0);
    chk("reset_mid_kept", rd_got[1], 32'h55AA0001);

    // randomized bursts with backpressure
    for (int it = 0; it < 40; it++) begin
      burst = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) burst = 3;
      size = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) size = 3;
      if (burst == 2) begin
        case ($urandom_range(0, 4))
          0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
        endcase
      end else begin
        len = $urandom_range(0, 15);
      end
      addr = BASE + ((32'($urandom_range(0, 4 * MW + 16)) >> size) << size);
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      axi_write(4'($urandom), addr, len, size, burst, -1, 0, 1'($urandom), resp);
      axi_read(4'($urandom), addr, len, size, burst, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
